// File: rtl/mult_arbiter_if.sv
// rtl/mult_arbiter_if.sv - requester, response and multiplier signal bundle for mult_arbiter
// Parameters: N operand width, NREQ requester count.
// Modports:
//   slave  - the arbiter: takes req_valid/req_a/req_b/rsp_ready/mul_out/mul_finish,
//            drives req_ready/rsp_valid/rsp_data/rsp_err/mul_a/mul_b/mul_start
//   master - the environment (requesters plus the shared multiplier), opposite directions
interface mult_arbiter_if #(
  parameter int N    = 5,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [2*N-1:0]    rsp_data;
  logic              rsp_err;
  logic [N-1:0]      mul_a;
  logic [N-1:0]      mul_b;
  logic              mul_start;
  logic [2*N-1:0]    mul_out;
  logic              mul_finish;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_out, mul_finish,
    output req_ready, rsp_valid, rsp_data, rsp_err, mul_a, mul_b, mul_start
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_out, mul_finish,
    input  req_ready, rsp_valid, rsp_data, rsp_err, mul_a, mul_b, mul_start
  );
endinterface

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one sequential multiplier among NREQ requesters
// Parameters: N operand width, NREQ requesters (2..8), TIMEOUT_CYC watchdog limit
//   (TIMEOUT_CYC exists only when MULT_ARB_TIMEOUT_EN is defined).
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - mult_arbiter_if.slave: per-requester req_valid/req_ready with packed
//           req_a/req_b, one-hot rsp_valid/rsp_ready with shared rsp_data/rsp_err,
//           and mul_a/mul_b/mul_start/mul_out/mul_finish to the multiplier.
// Optional feature: define MULT_ARB_TIMEOUT_EN to build the BUSY watchdog; otherwise
// BUSY waits indefinitely for mul_finish and rsp_err is tied to 0.
module mult_arbiter #(
  parameter int N    = 5,
  parameter int NREQ = 4
`ifdef MULT_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 2*N+4
`endif
) (
  input logic           clk,
  input logic           reset,
  mult_arbiter_if.slave bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, BUSY, RESP} state_t;

  state_t          state;
  state_t          state_nx;
  logic [GW-1:0]   rr;
  logic [GW-1:0]   gnt_id;
  logic [GW-1:0]   pick_id;
  logic            pick_ok;
  int              scan_idx;
  logic [N-1:0]    sel_a;
  logic [N-1:0]    sel_b;
  logic [N-1:0]    op_a;
  logic [N-1:0]    op_b;
  logic [2*N-1:0]  rsp_data_q;
  logic [NREQ-1:0] req_ready_c;
  logic [NREQ-1:0] rsp_valid_c;
  logic            start_c;
  logic            tmo_hit;

  // Circular scan starting at rr. No grant while reset is high so a requester
  // never sees an acceptance that the reset then throws away.
  always_comb begin
    pick_ok  = 1'b0;
    pick_id  = '0;
    scan_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = (int'(rr) + k) % NREQ;
      if (!pick_ok && !reset && bus.req_valid[GW'(scan_idx)]) begin
        pick_ok = 1'b1;
        pick_id = GW'(scan_idx);
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick_id == GW'(k)) begin
        sel_a = bus.req_a[k*N +: N];
        sel_b = bus.req_b[k*N +: N];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    req_ready_c = '0;
    rsp_valid_c = '0;
    start_c     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_ok) begin
          req_ready_c[pick_id] = 1'b1;
          state_nx             = LOAD;
        end
      end
      // One cycle with start low and operands already stable.
      LOAD: state_nx = BUSY;
      BUSY: begin
        start_c = 1'b1;
        if (bus.mul_finish || tmo_hit) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        rsp_valid_c[gnt_id] = 1'b1;
        if (bus.rsp_ready[gnt_id]) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr         <= '0;
      gnt_id     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rsp_data_q <= '0;
    end else begin
      if (state == IDLE && pick_ok) begin
        gnt_id <= pick_id;
        rr     <= GW'((int'(pick_id) + 1) % NREQ);
        op_a   <= sel_a;
        op_b   <= sel_b;
      end
      if (state == BUSY) begin
        if (bus.mul_finish) begin
          rsp_data_q <= bus.mul_out;
        end else if (tmo_hit) begin
          rsp_data_q <= '0;
        end
      end
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] tmo_cnt;
  logic          rsp_err_q;

  // Counter sits at 0 outside BUSY, so it is cleared on every entry to BUSY;
  // the hit fires in the TIMEOUT_CYC-th BUSY cycle without a finish.
  assign tmo_hit = (state == BUSY) && !bus.mul_finish && (tmo_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset || state != BUSY) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_err_q <= 1'b0;
    end else if (state == BUSY && bus.mul_finish) begin
      rsp_err_q <= 1'b0;
    end else if (tmo_hit) begin
      rsp_err_q <= 1'b1;
    end else if (state == RESP && bus.rsp_ready[gnt_id]) begin
      rsp_err_q <= 1'b0;
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.mul_a     = op_a;
  assign bus.mul_b     = op_b;
  assign bus.mul_start = start_c;
endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - self-checking bench for mult_arbiter
module tb_mult_arbiter;
  localparam int N    = 5;
  localparam int NREQ = 4;
  localparam int TMO  = 2*N+4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mult_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();
  mult_arbiter #(.N(N), .NREQ(NREQ)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors;
  int miscompares;

  // Multiplier stand-in: counts cycles with start high and raises finish with
  // the product after stub_lat of them; re-arms whenever start is low.
  int stub_cnt = 0;
  int stub_lat = N + 1;
  bit stub_en  = 1'b1;
  always @(negedge clk) begin
    if (bus.mul_start) begin
      stub_cnt++;
      if (stub_en && stub_cnt >= stub_lat) begin
        bus.mul_finish = 1'b1;
        bus.mul_out    = (2*N)'(bus.mul_a) * (2*N)'(bus.mul_b);
      end
    end else begin
      stub_cnt       = 0;
      bus.mul_finish = 1'b0;
      bus.mul_out    = '0;
    end
  end

  typedef struct {
    int id;
    int a;
    int b;
    int prod;
    int lat;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    bus.req_valid[i]     = 1'b1;
    bus.req_a[i*N +: N]  = N'(a);
    bus.req_b[i*N +: N]  = N'(b);
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (bus.rsp_valid == '0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int first;
    first = -1;
    @(negedge clk);
    bus.rsp_ready = '1;
    set_req(v.id, v.a, v.b);
    #1;
    chk("tbl_grant", bus.req_ready, 64'(1) << v.id);
    for (int c = 1; c <= 40 && first < 0; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = '0;
      #1;
      if (c == 1) chk("tbl_load_start", bus.mul_start, 0);
      if (c == 2) chk("tbl_busy_start", bus.mul_start, 1);
      if (bus.rsp_valid != '0) first = c;
    end
    chk("tbl_latency", first, v.lat);
    chk("tbl_rsp_valid", bus.rsp_valid, 64'(1) << v.id);
    chk("tbl_rsp_data", bus.rsp_data, v.prod);
    chk("tbl_rsp_err", bus.rsp_err, 0);
    @(negedge clk);
    #1;
    chk("tbl_rsp_clear", bus.rsp_valid, 0);
  endtask

  int ra[NREQ];
  int rb[NREQ];
  int ord[NREQ];
  int ord_n;

  task automatic rr_round();
    int n;
    int g;
    @(negedge clk);
    bus.rsp_ready = '1;
    for (int i = 0; i < NREQ; i++) if (ra[i] >= 0) set_req(i, ra[i], rb[i]);
    #1;
    for (int j = 0; j < ord_n; j++) begin
      g = ord[j];
      n = 0;
      while (bus.req_ready == '0 && n < 40) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("rr_grant", bus.req_ready, 64'(1) << g);
      @(negedge clk);
      bus.req_valid[g] = 1'b0;
      #1;
      wait_rsp();
      chk("rr_rsp_valid", bus.rsp_valid, 64'(1) << g);
      chk("rr_rsp_data", bus.rsp_data, ra[g] * rb[g]);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic back_pressure();
    do_reset();
    @(negedge clk);
    bus.rsp_ready = '0;
    set_req(2, 7, 9);
    #1;
    chk("bp_grant", bus.req_ready, 4'b0100);
    @(negedge clk);
    bus.req_valid = '0;
    set_req(1, 2, 3);
    #1;
    wait_rsp();
    chk("bp_rsp_valid", bus.rsp_valid, 4'b0100);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.rsp_ready = 4'b1011;
      #1;
      chk("bp_hold_valid", bus.rsp_valid, 4'b0100);
      chk("bp_hold_data", bus.rsp_data, 63);
      chk("bp_no_grant", bus.req_ready, 0);
    end
    @(negedge clk);
    bus.rsp_ready = 4'b0100;
    #1;
    chk("bp_handshake_valid", bus.rsp_valid, 4'b0100);
    @(negedge clk);
    bus.rsp_ready = '0;
    #1;
    chk("bp_next_grant", bus.req_ready, 4'b0010);
    @(negedge clk);
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    #1;
    wait_rsp();
    chk("bp_second_valid", bus.rsp_valid, 4'b0010);
    chk("bp_second_data", bus.rsp_data, 6);
    @(negedge clk);
    bus.rsp_ready = '0;
  endtask

  task automatic reset_mid_busy();
    do_reset();
    @(negedge clk);
    bus.rsp_ready = '1;
    set_req(0, 5, 6);
    #1;
    chk("rst_first_grant", bus.req_ready, 4'b0001);
    @(negedge clk);
    set_req(0, 9, 9);
    set_req(1, 4, 4);
    @(negedge clk);
    #1;
    chk("rst_busy_start", bus.mul_start, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_start_low", bus.mul_start, 0);
    chk("rst_no_rsp", bus.rsp_valid, 0);
    chk("rst_rr_zero_grant", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    #1;
    wait_rsp();
    chk("rst_fresh_valid", bus.rsp_valid, 4'b0001);
    chk("rst_fresh_data", bus.rsp_data, 81);
    @(negedge clk);
    #1;
    chk("rst_then_grant1", bus.req_ready, 4'b0010);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    wait_rsp();
    chk("rst_second_data", bus.rsp_data, 16);
    @(negedge clk);
  endtask

  task automatic no_finish();
    int first;
    do_reset();
    stub_en = 1'b0;
    @(negedge clk);
    bus.rsp_ready = '1;
    set_req(0, 3, 5);
    #1;
    chk("nf_grant", bus.req_ready, 4'b0001);
    first = -1;
    for (int c = 1; c <= 30 && first < 0; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = '0;
      #1;
      if (bus.rsp_valid != '0) first = c;
    end
`ifdef MULT_ARB_TIMEOUT_EN
    chk("nf_tmo_latency", first, 2 + TMO);
    chk("nf_tmo_valid", bus.rsp_valid, 4'b0001);
    chk("nf_tmo_err", bus.rsp_err, 1);
    chk("nf_tmo_data", bus.rsp_data, 0);
    @(negedge clk);
    #1;
    chk("nf_err_clear", bus.rsp_err, 0);
`else
    chk("nf_no_rsp", first, -1);
    chk("nf_start_held", bus.mul_start, 1);
`endif
    stub_en = 1'b1;
    do_reset();
  endtask

  // Reference: pending requests per requester, a round-robin pointer and at
  // most one outstanding product; grants and responses derive from those alone.
  task automatic rand_phase();
    bit              pend[NREQ];
    int              pa[NREQ];
    int              pb[NREQ];
    int              mrr;
    bit              infl;
    int              mid;
    int              mprod;
    int              wd;
    int              g;
    int              j;
    logic [NREQ-1:0] exp_rdy;
    do_reset();
    mrr   = 0;
    infl  = 1'b0;
    mid   = 0;
    mprod = 0;
    wd    = 0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      pa[i]   = 0;
      pb[i]   = 0;
    end
    for (int cy = 0; cy < 3000; cy++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          pa[i]   = int'($urandom_range(0, 31));
          pb[i]   = int'($urandom_range(0, 31));
        end else if (pend[i] && $urandom_range(0, 39) == 0) begin
          pend[i] = 1'b0;
        end
        bus.req_valid[i]    = pend[i];
        bus.req_a[i*N +: N] = N'(pa[i]);
        bus.req_b[i*N +: N] = N'(pb[i]);
      end
      bus.rsp_ready = NREQ'($urandom);
      #1;
      exp_rdy = '0;
      g = -1;
      if (!infl) begin
        for (int k = 0; k < NREQ; k++) begin
          j = (mrr + k) % NREQ;
          if (g < 0 && pend[j]) g = j;
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
      end
      chk("rnd_req_ready", bus.req_ready, exp_rdy);
      if (infl) begin
        if (bus.rsp_valid != '0) begin
          chk("rnd_rsp_valid", bus.rsp_valid, 64'(1) << mid);
          chk("rnd_rsp_data", bus.rsp_data, mprod);
          chk("rnd_rsp_err", bus.rsp_err, 0);
          if (bus.rsp_ready[mid]) infl = 1'b0;
        end else begin
          wd++;
          if (wd > 40) begin
            chk("rnd_rsp_timeout", bus.rsp_valid, 64'(1) << mid);
            infl = 1'b0;
          end
        end
      end else begin
        chk("rnd_no_rsp", bus.rsp_valid, 0);
      end
      if (g >= 0) begin
        infl     = 1'b1;
        mid      = g;
        mprod    = pa[g] * pb[g];
        pend[g]  = 1'b0;
        mrr      = (g + 1) % NREQ;
        wd       = 0;
        stub_lat = int'($urandom_range(1, 10));
      end
    end
    stub_lat = N + 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vectors       = 0;
    miscompares   = 0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '0;

    tbl[0] = '{0, 26, 30, 780, N + 3};
    tbl[1] = '{2,  7,  9,  63, N + 3};
    tbl[2] = '{1, 31, 31, 961, N + 3};
    tbl[3] = '{3,  0, 17,   0, N + 3};
    tbl[4] = '{0, 31,  0,   0, N + 3};
    tbl[5] = '{3,  1, 31,  31, N + 3};
    tbl[6] = '{1, 16, 16, 256, N + 3};
    tbl[7] = '{2, 31, 30, 930, N + 3};

    do_reset();
    @(negedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_mul_a", bus.mul_a, 0);
    chk("rst_mul_b", bus.mul_b, 0);
    chk("rst_mul_start", bus.mul_start, 0);

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    do_reset();
    ra    = '{13, 31, -1, 0};
    rb    = '{13, 31, -1, 17};
    ord   = '{0, 1, 3, 0};
    ord_n = 3;
    rr_round();
    ra    = '{1, 3, 5, 7};
    rb    = '{2, 4, 6, 8};
    ord   = '{0, 1, 2, 3};
    ord_n = 4;
    rr_round();

    back_pressure();
    reset_mid_busy();
    no_finish();
    rand_phase();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one sequential N-bit `multiplier` instance among NREQ requesters. It sits between the requesters and the multiplier. It captures one operand pair at a time and drives the multiplier's `a_in`/`b_in`/`start`. It waits for `finish`, then returns the 2N-bit product to the granted requester over a valid/ready handshake.

## Interface
- N, 5, operand width; must match the multiplier's N
- NREQ, 4, number of requesters (2..8)
- TIMEOUT_CYC, 2*N+4, watchdog limit in cycles (used only with MULT_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- req_valid  in  NREQ  per-requester request
- req_ready  out  NREQ  one-hot acceptance pulse
- req_a  in  NREQ*N  operand A, requester i at bits [i*N +: N]
- req_b  in  NREQ*N  operand B, same packing
- rsp_valid  out  NREQ  one-hot; product available for requester i
- rsp_ready  in  NREQ  requester accepts product
- rsp_data  out  2N  product, shared by all requesters
- rsp_err  out  1  timeout flag, qualified by rsp_valid; constant 0 without MULT_ARB_TIMEOUT_EN
- mul_a, mul_b  out  N  to multiplier `a_in`/`b_in`
- mul_start  out  1  to multiplier `start`
- mul_out  in  2N  from multiplier `out`
- mul_finish  in  1  from multiplier `finish`

## Operation
- FSM states are IDLE, LOAD, BUSY and RESP.
- **IDLE**
  - Pick the first requester with req_valid high, scanning circularly from pointer `rr` (reset 0).
  - Pulse req_ready[g] for that cycle.
  - Capture req_a/req_b slice g into the operand registers.
  - Update rr to (g+1) mod NREQ.
  - Go to LOAD.
  - If no requester has req_valid high, stay in IDLE.
- **LOAD**
  - Hold mul_a/mul_b at the captured operands and mul_start at 0 for one cycle.
  - Go to BUSY.
- **BUSY**
  - Hold mul_start at 1 and keep the operands stable.
  - When mul_finish is 1, register mul_out into rsp_data, drop mul_start and go to RESP.
- **RESP**
  - Hold rsp_valid[g] at 1 and rsp_data stable, with mul_start at 0.
  - When rsp_ready[g] is 1, clear rsp_valid and go to IDLE.
  - rsp_ready on any other bit is ignored.
- Only one operation is in flight. Requesters that are not granted keep req_valid high and are not dropped.
- mul_start is always low for at least 2 cycles (RESP and IDLE) between operations, which re-arms the multiplier.
- Products are unsigned: rsp_data = req_a × req_b, 2N bits wide, with no truncation.

## Timing
- All outputs reset to 0: req_ready, rsp_valid, rsp_data, rsp_err, mul_a, mul_b and mul_start. The FSM resets to IDLE and rr to 0.
- Request-to-response latency, with rsp_ready held high:
  - req_ready at cycle 0
  - LOAD at cycle 1
  - mul_start rises at cycle 2
  - rsp_valid asserts the cycle after mul_finish is sampled high
- With the standard multiplier that is N+3 cycles.
- Back-to-back operation: a new grant is possible in the cycle after the RESP handshake.
- mul_finish is ignored outside BUSY.
- A requester whose req_valid drops before it is granted is simply skipped; the block never grants a requester whose req_valid is low.
- Reset asserted in any state takes effect at the next edge:
  - the operation is abandoned;
  - mul_start drops;
  - no response is produced;
  - rr returns to 0.

## Configuration
- `MULT_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to BUSY and increments on each BUSY cycle.
  - If it reaches TIMEOUT_CYC without mul_finish, go to RESP with rsp_data=0 and rsp_err=1.
  - rsp_err clears when the response is accepted.
- `MULT_ARB_TIMEOUT_EN` undefined:
  - No counter is built and rsp_err is tied to 0.
  - BUSY waits indefinitely for mul_finish.

## Test plan
All scenarios use N=5 and NREQ=4.
- **Single request.** Reset, then req 0 with a=26, b=30 and rsp_ready held high.
  - req_ready[0] pulses at cycle 0.
  - rsp_valid[0] and rsp_data=780 appear at cycle N+3=8.
  - rsp_err=0.
- **Round-robin order.** Requesters 0, 1 and 3 are valid simultaneously with operands (13,13), (31,31) and (0,17).
  - Grants go 0 → 1 → 3.
  - Responses are 169, 961 and 0.
  - A second round with all four valid starts at requester 0 (rr wrapped after 3).
- **Back-pressure.** Hold rsp_ready[2] low for 10 cycles after rsp_valid[2] asserts (a=7, b=9).
  - rsp_data=63 stays stable throughout.
  - No new grant is made while another requester waits.
  - Grant follows 1 cycle after the handshake.
- **Reset mid-BUSY.** Assert reset 2 cycles into BUSY.
  - Next cycle: mul_start=0, rsp_valid=0, rr=0.
  - A fresh request completes normally.
- **Timeout (`MULT_ARB_TIMEOUT_EN`).** Use a stub multiplier that never asserts mul_finish.
  - rsp_valid asserts with rsp_err=1 and rsp_data=0 after TIMEOUT_CYC=14 BUSY cycles.
  - Without the macro, no response is produced.
